// File: rtl/serial_add2_if.sv
// Handshake/operand bundle for serial_add2.
// Define SERIAL_ADD2_OVF_EN to add the signed-overflow flag ovf.
interface serial_add2_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
`ifdef SERIAL_ADD2_OVF_EN
  logic             ovf;

  modport master (
    output start, a, b, cin,
    input  busy, done, sum, cout, ovf
  );

  modport slave (
    input  start, a, b, cin,
    output busy, done, sum, cout, ovf
  );
`else
  modport master (
    output start, a, b, cin,
    input  busy, done, sum, cout
  );

  modport slave (
    input  start, a, b, cin,
    output busy, done, sum, cout
  );
`endif
endinterface

// File: rtl/serial_add2.sv
// Two-bit-per-cycle serial adder: sum/cout = a + b + cin after WIDTH/2 RUN cycles.
// Define SERIAL_ADD2_OVF_EN to add the registered signed-overflow output ovf.
module serial_add2 #(
  parameter int WIDTH = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  serial_add2_if.slave  bus
);

  localparam int NPAIRS = WIDTH / 2;
  localparam int CW     = (NPAIRS > 1) ? $clog2(NPAIRS) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_reg;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [WIDTH-1:0] psum_reg;
  logic [WIDTH-1:0] sum_reg;
  logic [CW-1:0]    cnt_reg;
  logic             carry_reg;
  logic             cout_reg;
  logic             busy_reg;
  logic             done_reg;

  logic [1:0]       p_bit;
  logic [1:0]       g_bit;
  logic             c_mid;
  logic             carry_next;
  logic [1:0]       pair_next;
  logic [WIDTH-1:0] psum_next;
  logic             last_pair;

  // Per-bit propagate/generate for the current operand pair.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_pair
      assign p_bit[gi] = a_reg[gi] ^ b_reg[gi];
      assign g_bit[gi] = a_reg[gi] & b_reg[gi];
    end
  endgenerate

  assign c_mid      = g_bit[0] | (p_bit[0] & carry_reg);
  assign carry_next = g_bit[1] | (p_bit[1] & c_mid);
  assign pair_next  = {p_bit[1] ^ c_mid, p_bit[0] ^ carry_reg};
  // New pair enters at the MSB end so after the last pair it sits in place.
  assign psum_next  = {pair_next, psum_reg[WIDTH-1:2]};
  assign last_pair  = (cnt_reg == CW'(NPAIRS - 1));

`ifdef SERIAL_ADD2_OVF_EN
  logic a_msb_reg;
  logic b_msb_reg;
  logic ovf_reg;
  logic ovf_next;

  // Operand MSBs are kept separately because a_reg/b_reg shift away.
  assign ovf_next = (a_msb_reg == b_msb_reg) && (psum_next[WIDTH-1] != a_msb_reg);
  assign bus.ovf  = ovf_reg;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      a_reg     <= '0;
      b_reg     <= '0;
      psum_reg  <= '0;
      sum_reg   <= '0;
      cnt_reg   <= '0;
      carry_reg <= 1'b0;
      cout_reg  <= 1'b0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
`ifdef SERIAL_ADD2_OVF_EN
      a_msb_reg <= 1'b0;
      b_msb_reg <= 1'b0;
      ovf_reg   <= 1'b0;
`endif
    end else begin
      case (state_reg)
        IDLE: begin
          done_reg <= 1'b0;
          if (bus.start) begin
            a_reg     <= bus.a;
            b_reg     <= bus.b;
            carry_reg <= bus.cin;
            psum_reg  <= '0;
            cnt_reg   <= '0;
            busy_reg  <= 1'b1;
            state_reg <= RUN;
`ifdef SERIAL_ADD2_OVF_EN
            a_msb_reg <= bus.a[WIDTH-1];
            b_msb_reg <= bus.b[WIDTH-1];
`endif
          end
        end

        RUN: begin
          a_reg     <= {2'b00, a_reg[WIDTH-1:2]};
          b_reg     <= {2'b00, b_reg[WIDTH-1:2]};
          carry_reg <= carry_next;
          psum_reg  <= psum_next;
          cnt_reg   <= cnt_reg + CW'(1);
          if (last_pair) begin
            sum_reg   <= psum_next;
            cout_reg  <= carry_next;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b1;
            state_reg <= DONE;
`ifdef SERIAL_ADD2_OVF_EN
            ovf_reg   <= ovf_next;
`endif
          end
        end

        DONE: begin
          done_reg  <= 1'b0;
          state_reg <= IDLE;
        end

        default: begin
          busy_reg  <= 1'b0;
          done_reg  <= 1'b0;
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy = busy_reg;
  assign bus.done = done_reg;
  assign bus.sum  = sum_reg;
  assign bus.cout = cout_reg;

endmodule

// File: tb/tb_serial_add2.sv
// Directed self-checking bench for serial_add2 (WIDTH=8); define
// SERIAL_ADD2_OVF_EN to also exercise the overflow flag.
module tb_serial_add2;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  serial_add2_if #(.WIDTH(8)) bus ();

  serial_add2 #(.WIDTH(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Issue one addition and wait (bounded) for done. Returns at the negedge
  // inside the done cycle. lat counts negedges after the accepting edge.
  task automatic run_op(input logic [7:0] ta, input logic [7:0] tb_v, input logic tc,
                        input bit release_rst, output int busy_cnt, output int lat,
                        output bit tmo, output logic [7:0] mid_sum, output logic mid_cout);
    @(negedge clk);
    if (release_rst) rst_n = 1'b1;
    bus.start = 1'b1;
    bus.a     = ta;
    bus.b     = tb_v;
    bus.cin   = tc;
    @(negedge clk);
    bus.start = 1'b0;
    bus.a     = ~ta;
    bus.b     = ~tb_v;
    bus.cin   = ~tc;
    busy_cnt  = 0;
    lat       = 0;
    tmo       = 1'b1;
    mid_sum   = bus.sum;
    mid_cout  = bus.cout;
    for (int i = 0; i < 20; i++) begin
      lat++;
      if (bus.done === 1'b1) begin
        tmo = 1'b0;
        break;
      end
      if (bus.busy === 1'b1) begin
        busy_cnt++;
        mid_sum  = bus.sum;
        mid_cout = bus.cout;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst_n     = 1'b1;
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    bus.cin   = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
    checks++;
    if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", bus.done); end
    checks++;
    if (bus.sum !== 8'h00) begin errors++; $display("FAIL reset_sum: got %h expected 00", bus.sum); end
    checks++;
    if (bus.cout !== 1'b0) begin errors++; $display("FAIL reset_cout: got %b expected 0", bus.cout); end
`ifdef SERIAL_ADD2_OVF_EN
    checks++;
    if (bus.ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b expected 0", bus.ovf); end
`endif
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    $display("test_reset: outputs zero during reset");
  endtask

  task automatic test_basic();
    int bc, lat;
    bit tmo;
    logic [7:0] ms;
    logic mc;
    run_op(8'hFF, 8'h01, 1'b0, 1'b0, bc, lat, tmo, ms, mc);
    checks++;
    if (tmo) begin errors++; $display("FAIL basic_timeout: got no done expected done"); end
    checks++;
    if (bc != 4) begin errors++; $display("FAIL basic_busy_cycles: got %0d expected 4", bc); end
    checks++;
    if (lat != 5) begin errors++; $display("FAIL basic_latency: got %0d expected 5", lat); end
    checks++;
    if (bus.sum !== 8'h00) begin errors++; $display("FAIL basic_sum: got %h expected 00", bus.sum); end
    checks++;
    if (bus.cout !== 1'b1) begin errors++; $display("FAIL basic_cout: got %b expected 1", bus.cout); end
    @(negedge clk);
    checks++;
    if (bus.done !== 1'b0) begin errors++; $display("FAIL basic_done_width: got %b expected 0", bus.done); end
    $display("test_basic: FF+01+0 -> sum=%h cout=%b busy=%0d lat=%0d", bus.sum, bus.cout, bc, lat);
  endtask

  task automatic test_hold();
    logic [7:0] va [5]   = '{8'h5A, 8'h12, 8'h80, 8'hA5, 8'h0F};
    logic [7:0] vb [5]   = '{8'hA5, 8'h34, 8'h80, 8'h3C, 8'h01};
    logic       vc [5]   = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    logic [7:0] es [5]   = '{8'h00, 8'h46, 8'h01, 8'hE1, 8'h11};
    logic       ec [5]   = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    logic [7:0] prev_s   = 8'h00;
    logic       prev_c   = 1'b1;
    int bc, lat;
    bit tmo;
    logic [7:0] ms;
    logic mc;
    for (int i = 0; i < 5; i++) begin
      run_op(va[i], vb[i], vc[i], 1'b0, bc, lat, tmo, ms, mc);
      checks++;
      if (tmo) begin errors++; $display("FAIL hold_timeout[%0d]: got no done expected done", i); end
      checks++;
      if (ms !== prev_s || mc !== prev_c)
        begin errors++; $display("FAIL hold_prev[%0d]: got %h/%b expected %h/%b", i, ms, mc, prev_s, prev_c); end
      checks++;
      if (bus.sum !== es[i]) begin errors++; $display("FAIL hold_sum[%0d]: got %h expected %h", i, bus.sum, es[i]); end
      checks++;
      if (bus.cout !== ec[i]) begin errors++; $display("FAIL hold_cout[%0d]: got %b expected %b", i, bus.cout, ec[i]); end
      $display("test_hold: %h+%h+%b -> sum=%h cout=%b", va[i], vb[i], vc[i], bus.sum, bus.cout);
      prev_s = es[i];
      prev_c = ec[i];
    end
  endtask

  task automatic test_ignore_start();
    int dones;
    bit got;
    @(negedge clk);
    bus.start = 1'b1;
    bus.a = 8'h12; bus.b = 8'h01; bus.cin = 1'b0;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    bus.start = 1'b1;
    bus.a = 8'hFF; bus.b = 8'hFF; bus.cin = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      if (bus.done === 1'b1) got = 1'b1;
      else @(negedge clk);
    end
    checks++;
    if (!got) begin errors++; $display("FAIL ignore_timeout: got no done expected done"); end
    checks++;
    if (bus.sum !== 8'h13) begin errors++; $display("FAIL ignore_sum: got %h expected 13", bus.sum); end
    checks++;
    if (bus.cout !== 1'b0) begin errors++; $display("FAIL ignore_cout: got %b expected 0", bus.cout); end
    dones = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (bus.done === 1'b1 || bus.busy === 1'b1) dones++;
    end
    checks++;
    if (dones != 0) begin errors++; $display("FAIL ignore_extra_op: got %0d active cycles expected 0", dones); end
    $display("test_ignore_start: 12+01 -> sum=%h cout=%b", bus.sum, bus.cout);
  endtask

  task automatic test_reset_mid();
    int bc, lat, dones;
    bit tmo;
    logic [7:0] ms;
    logic mc;
    @(negedge clk);
    bus.start = 1'b1;
    bus.a = 8'hFF; bus.b = 8'h02; bus.cin = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0)
      begin errors++; $display("FAIL midrst_ctrl: got busy=%b done=%b expected 0/0", bus.busy, bus.done); end
    checks++;
    if (bus.sum !== 8'h00 || bus.cout !== 1'b0)
      begin errors++; $display("FAIL midrst_result: got %h/%b expected 00/0", bus.sum, bus.cout); end
    dones = 0;
    repeat (3) begin
      @(negedge clk);
      if (bus.done === 1'b1) dones++;
    end
    checks++;
    if (dones != 0) begin errors++; $display("FAIL midrst_done: got %0d pulses expected 0", dones); end
    run_op(8'h21, 8'h21, 1'b0, 1'b1, bc, lat, tmo, ms, mc);
    checks++;
    if (tmo || lat != 5) begin errors++; $display("FAIL midrst_restart_lat: got %0d expected 5", lat); end
    checks++;
    if (bus.sum !== 8'h42 || bus.cout !== 1'b0)
      begin errors++; $display("FAIL midrst_restart: got %h/%b expected 42/0", bus.sum, bus.cout); end
    $display("test_reset_mid: abort then 21+21 -> sum=%h cout=%b", bus.sum, bus.cout);
  endtask

  task automatic test_back_to_back();
    int pulses, last_idx, bad_gap, first_idx;
    logic [7:0] first_sum;
    @(negedge clk);
    bus.start = 1'b1;
    bus.a = 8'h01; bus.b = 8'h02; bus.cin = 1'b0;
    pulses = 0; last_idx = -1; bad_gap = 0; first_idx = -1; first_sum = 8'hXX;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      if (bus.done === 1'b1) begin
        pulses++;
        if (first_idx < 0) begin first_idx = i; first_sum = bus.sum; end
        if (last_idx >= 0 && i - last_idx != 6) bad_gap++;
        last_idx = i;
      end
    end
    bus.start = 1'b0;
    checks++;
    if (pulses != 5) begin errors++; $display("FAIL b2b_pulses: got %0d expected 5", pulses); end
    checks++;
    if (first_idx != 5) begin errors++; $display("FAIL b2b_first: got %0d expected 5", first_idx); end
    checks++;
    if (bad_gap != 0) begin errors++; $display("FAIL b2b_interval: got %0d bad gaps expected 0", bad_gap); end
    checks++;
    if (first_sum !== 8'h03) begin errors++; $display("FAIL b2b_sum: got %h expected 03", first_sum); end
    repeat (8) @(negedge clk);
    $display("test_back_to_back: %0d done pulses, first at %0d", pulses, first_idx);
  endtask

`ifdef SERIAL_ADD2_OVF_EN
  task automatic test_ovf();
    int bc, lat;
    bit tmo;
    logic [7:0] ms;
    logic mc;
    run_op(8'h7F, 8'h01, 1'b0, 1'b0, bc, lat, tmo, ms, mc);
    checks++;
    if (tmo || bus.sum !== 8'h80 || bus.ovf !== 1'b1)
      begin errors++; $display("FAIL ovf_pos: got %h/%b expected 80/1", bus.sum, bus.ovf); end
    run_op(8'h80, 8'h7F, 1'b0, 1'b0, bc, lat, tmo, ms, mc);
    checks++;
    if (tmo || bus.sum !== 8'hFF || bus.ovf !== 1'b0)
      begin errors++; $display("FAIL ovf_mixed: got %h/%b expected FF/0", bus.sum, bus.ovf); end
    run_op(8'h80, 8'h80, 1'b0, 1'b0, bc, lat, tmo, ms, mc);
    checks++;
    if (tmo || bus.sum !== 8'h00 || bus.ovf !== 1'b1)
      begin errors++; $display("FAIL ovf_neg: got %h/%b expected 00/1", bus.sum, bus.ovf); end
    $display("test_ovf: last sum=%h ovf=%b", bus.sum, bus.ovf);
  endtask
`endif

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_basic();
    test_hold();
    test_ignore_start();
    test_reset_mid();
    test_back_to_back();
`ifdef SERIAL_ADD2_OVF_EN
    test_ovf();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_add2.md
SERIAL_ADD2 -- requirements
Module: serial_add2

Interface
REQ-001 Parameter WIDTH, default 8, operand width in bits; SHALL be even and >= 4.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 start  input  1  request to begin an addition; sampled on the rising edge of clk.
REQ-005 a  input  WIDTH  first operand; captured when start is accepted.
REQ-006 b  input  WIDTH  second operand; captured when start is accepted.
REQ-007 cin  input  1  carry-in; captured when start is accepted.
REQ-008 busy  output  1  high while an addition is in progress.
REQ-009 done  output  1  one-cycle pulse marking a valid result.
REQ-010 sum  output  WIDTH  registered result of a+b+cin, modulo 2^WIDTH.
REQ-011 cout  output  1  registered carry-out of the full WIDTH-bit addition.

Function
REQ-012 Datapath SHALL process 2 bits per cycle, least-significant pair first: {c',s1,s0} = a_reg[1:0] + b_reg[1:0] + carry.
REQ-013 The carry flip-flop SHALL hold the ripple carry between pairs; it is loaded with cin at start acceptance.
REQ-014 FSM states SHALL be IDLE, RUN and DONE.
REQ-015 IDLE with start=1: capture a, b and cin; clear the pair counter; go to RUN. IDLE with start=0: stay in IDLE.
REQ-016 RUN, each cycle: add the current pair; shift a_reg and b_reg right by 2; shift {s1,s0} into the partial-sum register from the MSB end; increment the counter.
REQ-017 RUN SHALL last exactly WIDTH/2 cycles. On the final pair, transfer the partial sum to sum and the final carry to cout, then go to DONE.
REQ-018 DONE SHALL last exactly one cycle, then return to IDLE unconditionally.
REQ-019 busy SHALL equal (state==RUN). done SHALL equal (state==DONE).
REQ-020 Latency: start accepted at edge k gives done=1 in the cycle after edge k+WIDTH/2; total busy cycles = WIDTH/2.
REQ-021 start SHALL be ignored in RUN and DONE. There is no queueing, and captured operands are not disturbed.
REQ-022 The next start SHALL be accepted no earlier than the first IDLE cycle after DONE, so the minimum issue interval is WIDTH/2+2 cycles.
REQ-023 sum and cout SHALL change only on the RUN->DONE transition and hold until the next completed addition. Partial results SHALL never appear on sum.
REQ-024 Changes on a, b and cin after start acceptance SHALL NOT affect the result.

Reset
REQ-025 On rst_n low, immediately and independent of clk: state=IDLE; busy=0; done=0; sum=0; cout=0; carry=0; counter=0; operand registers=0.
REQ-026 Reset asserted mid-RUN SHALL abort the operation; no done pulse is produced, and sum and cout read 0.
REQ-027 Deassertion of rst_n SHALL be recognised synchronously. The first start is accepted on the first rising edge where rst_n=1.

Configuration
REQ-028 Macro SERIAL_ADD2_OVF_EN SHALL control the signed-overflow feature.
REQ-029 With SERIAL_ADD2_OVF_EN defined: add output port ovf, 1 bit, registered, updated together with sum.
REQ-030 ovf SHALL equal (a[MSB]==b[MSB]) && (sum[MSB]!=a[MSB]), computed on the captured operands, two's complement. ovf resets to 0.
REQ-031 Without the macro: no ovf port and no overflow logic; all other behaviour is identical.

Verification (WIDTH=8)
REQ-032 a=0xFF, b=0x01, cin=0, start pulsed at edge k -> busy high for 4 cycles; done=1 after edge k+4; sum=0x00; cout=1.
REQ-033 a=0x5A, b=0xA5, cin=1 -> sum=0x00, cout=1. Then a=0x12, b=0x34, cin=0 -> sum=0x46, cout=0, with the previous result held until the second done.
REQ-034 During RUN, pulse start with a=0xFF, b=0xFF -> ignored; the first operation completes with its own result; no extra done pulse.
REQ-035 rst_n low at the third RUN cycle -> busy, done, sum and cout read 0 immediately; a start after release completes normally.
REQ-036 With SERIAL_ADD2_OVF_EN: a=0x7F, b=0x01, cin=0 -> sum=0x80, ovf=1. Then a=0x80, b=0x7F -> sum=0xFF, ovf=0.
REQ-037 Hold start high continuously -> an addition starts every 6 cycles; done pulses are exactly 1 cycle wide.
